register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port general-purpose register file for the MIPS datapath.
- Provides NUM_RD_PORTS asynchronous read ports and two synchronous write ports (ALU writeback port 0, load writeback port 1).
- Optional same-cycle write-to-read bypass and hardwired-zero R0.
- Includes a sequenced clear engine that zeroes the file one entry per cycle on request, without asserting reset.

Parameters:
REGISTER_DEPTH, 32, number of registers (2..2**ADDR_WIDTH)
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
NUM_RD_PORTS, 2, number of read ports (1..4)
BYPASS, 1, 1 = read returns same-cycle write data on address match
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  input  1  clock, all state updates on rising edge
reset_b  input  1  asynchronous active-low reset
rd_addr  input  NUM_RD_PORTS*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_RD_PORTS*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
wr_en0  input  1  write enable, port 0
wr_addr0  input  ADDR_WIDTH  write address, port 0
wr_data0  input  DATA_WIDTH  write data, port 0
wr_en1  input  1  write enable, port 1
wr_addr1  input  ADDR_WIDTH  write address, port 1
wr_data1  input  DATA_WIDTH  write data, port 1
clr_req  input  1  start sequenced clear (sampled in IDLE only)
clr_busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse on clear completion

Behaviour:
- Reset (reset_b=0, asynchronous):
  - All REGISTER_DEPTH entries, including the highest index, become 0.
  - Clear FSM goes to IDLE; clr_busy=0, clr_done=0.
  - rd_data reflects zeros combinationally.
- Reads: combinational from array, zero latency.
  - Address >= REGISTER_DEPTH reads 0.
  - ZERO_REG=1: address 0 always reads 0.
- Bypass (BYPASS=1): if wr_enN=1 and wr_addrN equals rd_addr of port k (valid, non-zero when ZERO_REG=1), rd_data of port k returns wr_dataN in the same cycle.
  - Both write ports match: wr_data1 is returned.
  - BYPASS=0: the old value is returned until the next edge.
- Writes: on rising clk edge when wr_enN=1.
  - Both ports target the same address: port 1 wins.
  - Writes to address >= REGISTER_DEPTH are dropped.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Clear FSM, states IDLE, CLEAR, DONE; pointer clr_ptr is ADDR_WIDTH bits.
  - IDLE: clr_req=1 -> CLEAR, clr_ptr=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to entry clr_ptr and increments clr_ptr. When clr_ptr=REGISTER_DEPTH-1 is cleared -> DONE. Total REGISTER_DEPTH cycles in CLEAR.
  - DONE: clr_done=1, clr_busy=0 for exactly one cycle -> IDLE.
  - clr_req is ignored in CLEAR and DONE. A held clr_req in IDLE restarts the sequence after DONE.
- Writes during CLEAR:
  - External writes to addresses < clr_ptr (already cleared) are accepted normally.
  - Writes to addresses >= clr_ptr are dropped.
  - A write to the same address being cleared this cycle is dropped; the clear wins.
  - Bypass still operates on accepted writes only.
- Reset asserted mid-clear: everything zeroed immediately, FSM IDLE, no clr_done pulse.
- Outputs clr_busy and clr_done are registered. No combinational path from clr_req to any output.

Test Plan:
- Reset check: preload 0xA5A5A5A5 to regs 1..31, pulse reset_b low 1 cycle -> every port reads 0x00000000 for all addresses including 31; clr_busy=0.
- Basic write/read: write 0x12345678 to r5 via port 0 and 0xCAFEF00D to r6 via port 1 in the same cycle -> next cycle rd_addr {5,6} returns {0x12345678, 0xCAFEF00D}.
- R0 handling and bypass: with ZERO_REG=1, write 0xFFFFFFFF to r0 -> reads 0. Then, with BYPASS=1, write 0x00000042 to r7 while rd_addr=7 -> rd_data=0x00000042 in the same cycle. With BYPASS=0 it returns the old value.
- Write collision: both ports write r9 (port 0 0x11111111, port 1 0x22222222) -> r9=0x22222222; same-cycle bypass read also returns 0x22222222.
- Sequenced clear:
  - Fill regs with their index, pulse clr_req.
  - clr_busy is high for exactly 32 cycles, then clr_done pulses 1 cycle, then all reads are 0.
  - Mid-clear (clr_ptr=10): a write of 0xBEEF to r3 is kept; a write to r20 is dropped.
- Reset mid-clear: assert reset_b low at clr_ptr=15 -> clr_busy=0 immediately after reset, no clr_done pulse, all entries 0; a new clr_req then completes normally.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port GPR file: async reads with optional write bypass, two write ports (port 1 wins), sequenced clear engine.
// Reads are zero-latency, writes land on the rising edge; a running clear drops writes at or above its pointer.
module register_file_mp #(
    parameter int REGISTER_DEPTH = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_RD_PORTS   = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG       = 1
) (
    input  logic                               clk,
    input  logic                               reset_b,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                               wr_en0,
    input  logic [ADDR_WIDTH-1:0]              wr_addr0,
    input  logic [DATA_WIDTH-1:0]              wr_data0,
    input  logic                               wr_en1,
    input  logic [ADDR_WIDTH-1:0]              wr_addr1,
    input  logic [DATA_WIDTH-1:0]              wr_data1,
    input  logic                               clr_req,
    output logic                               clr_busy,
    output logic                               clr_done
);

    localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH+1)'(REGISTER_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(REGISTER_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] regs [REGISTER_DEPTH];
    logic                  clearing;
    logic                  acc0;
    logic                  acc1;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        addr_ok = ({1'b0, a} < REG_LIMIT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Entries below the clear pointer are already zeroed and may be rewritten.
    assign clearing = (state == CLEAR);
    assign acc0 = wr_en0 && addr_ok(wr_addr0) && (!clearing || (wr_addr0 < clr_ptr));
    assign acc1 = wr_en1 && addr_ok(wr_addr1) && (!clearing || (wr_addr1 < clr_ptr));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                if (clearing && (clr_ptr == ADDR_WIDTH'(i))) begin
                    regs[i] <= '0;
                end else if (acc1 && (wr_addr1 == ADDR_WIDTH'(i))) begin
                    regs[i] <= wr_data1;
                end else if (acc0 && (wr_addr0 == ADDR_WIDTH'(i))) begin
                    regs[i] <= wr_data0;
                end
            end
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;

        assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Port 1 bypass is applied last so it wins a double match.
        always_comb begin
            rv = '0;
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                if (ra == ADDR_WIDTH'(i)) rv = regs[i];
            end
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
            if (BYPASS != 0) begin
                if (acc0 && (wr_addr0 == ra)) rv = wr_data0;
                if (acc1 && (wr_addr1 == ra)) rv = wr_data1;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rv;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing instance and a non-bypassing twin share all inputs.
module tb_register_file_mp;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 2;

    logic             clk = 1'b0;
    logic             reset_b;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data, rd_data_nb;
    logic             wr_en0, wr_en1;
    logic [AW-1:0]    wr_addr0, wr_addr1;
    logic [DW-1:0]    wr_data0, wr_data1;
    logic             clr_req;
    logic             clr_busy, clr_done, clr_busy_nb, clr_done_nb;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp;

    always #5 clk = ~clk;

    register_file_mp #(.REGISTER_DEPTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .NUM_RD_PORTS(NP), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset_b(reset_b), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done));

    register_file_mp #(.REGISTER_DEPTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .NUM_RD_PORTS(NP), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset_b(reset_b), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb));

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic write_cycle(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
        wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
        @(negedge clk);
        wr_en0 = 1'b0; wr_en1 = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", clr_busy, clr_done);
        end
        for (int i = 1; i < 32; i++) write_cycle(1'b1, AW'(i), 32'hA5A5A5A5, 1'b0, '0, '0);
        set_rd(5'd31, 5'd1); #1;
        exp_q.push_back(32'hA5A5A5A5);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL preload_r31 got %h expected %h", rd_data[31:0], exp);
        end
        @(negedge clk); reset_b = 1'b0; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL async_reset_r31 got %h expected %h", rd_data[31:0], exp);
        end
        @(negedge clk); reset_b = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk); set_rd(AW'(a), AW'(31 - a)); #1;
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            exp = exp_q.pop_front(); checks++;
            if (rd_data[31:0] !== exp) begin
                errors++; $display("FAIL reset_p0 addr %0d got %h expected %h", a, rd_data[31:0], exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (rd_data[63:32] !== exp) begin
                errors++; $display("FAIL reset_p1 addr %0d got %h expected %h", 31 - a, rd_data[63:32], exp);
            end
        end
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b expected 0", clr_busy);
        end
    endtask

    task automatic test_basic_write;
        @(negedge clk);
        write_cycle(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd6, 32'hCAFEF00D);
        set_rd(5'd5, 5'd6); #1;
        exp_q.push_back(32'h12345678); exp_q.push_back(32'hCAFEF00D);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL basic_r5 got %h expected %h", rd_data[31:0], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== exp) begin
            errors++; $display("FAIL basic_r6 got %h expected %h", rd_data[63:32], exp);
        end
    endtask

    task automatic test_zero_bypass;
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFFFFFF; set_rd(5'd0, 5'd0); #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL r0_same_cycle got %h expected %h", rd_data[31:0], exp);
        end
        @(negedge clk); wr_en0 = 1'b0; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL r0_after_write got %h expected %h", rd_data[31:0], exp);
        end
        @(negedge clk);
        write_cycle(1'b1, 5'd7, 32'h00000077, 1'b0, '0, '0);
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h00000042; set_rd(5'd7, 5'd7); #1;
        exp_q.push_back(32'h00000042); exp_q.push_back(32'h00000077);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL bypass_r7 got %h expected %h", rd_data[31:0], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data_nb[31:0] !== exp) begin
            errors++; $display("FAIL nobypass_r7 got %h expected %h", rd_data_nb[31:0], exp);
        end
        @(negedge clk); wr_en0 = 1'b0; #1;
        exp_q.push_back(32'h00000042); exp_q.push_back(32'h00000042);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL r7_after got %h expected %h", rd_data[31:0], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data_nb[63:32] !== exp) begin
            errors++; $display("FAIL nb_r7_after got %h expected %h", rd_data_nb[63:32], exp);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h11111111;
        wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h22222222;
        set_rd(5'd9, 5'd9); #1;
        exp_q.push_back(32'h22222222); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== exp) begin
            errors++; $display("FAIL collide_bypass got %h expected %h", rd_data[63:32], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data_nb[31:0] !== exp) begin
            errors++; $display("FAIL collide_nb_old got %h expected %h", rd_data_nb[31:0], exp);
        end
        @(negedge clk); wr_en0 = 1'b0; wr_en1 = 1'b0; #1;
        exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL collide_r9 got %h expected %h", rd_data[31:0], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data_nb[63:32] !== exp) begin
            errors++; $display("FAIL collide_nb_r9 got %h expected %h", rd_data_nb[63:32], exp);
        end
    endtask

    // Runs one clear sequence from the current negedge, returning busy/done counts.
    task automatic run_clear(input logic mid_writes, output int busy_cnt, output int done_cnt,
                             output int done_at);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        clr_req = 1'b1; @(negedge clk); clr_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            wr_en0 = 1'b0; wr_en1 = 1'b0; clr_req = 1'b0;
            if (clr_done) begin done_cnt++; done_at = c; end
            if (clr_busy) begin
                if (mid_writes && busy_cnt == 5) clr_req = 1'b1;
                if (mid_writes && (busy_cnt == 10 || busy_cnt == 11)) begin
                    if (busy_cnt == 10) begin
                        wr_en0 = 1'b1; wr_addr0 = 5'd3;  wr_data0 = 32'h0000BEEF;
                        wr_en1 = 1'b1; wr_addr1 = 5'd20; wr_data1 = 32'h0000DEAD;
                    end
                    set_rd(5'd3, 5'd20); #1;
                    exp_q.push_back(32'h0000BEEF); exp_q.push_back(32'd20);
                    exp = exp_q.pop_front(); checks++;
                    if (rd_data[31:0] !== exp) begin
                        errors++; $display("FAIL midclear_r3 cnt %0d got %h expected %h", busy_cnt, rd_data[31:0], exp);
                    end
                    exp = exp_q.pop_front(); checks++;
                    if (rd_data[63:32] !== exp) begin
                        errors++; $display("FAIL midclear_r20 cnt %0d got %h expected %h", busy_cnt, rd_data[63:32], exp);
                    end
                end
                busy_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear;
        int busy_cnt, done_cnt, done_at;
        for (int i = 0; i < 32; i += 2)
            write_cycle(1'b1, AW'(i), DW'(i), 1'b1, AW'(i + 1), DW'(i + 1));
        set_rd(5'd13, 5'd31); #1;
        checks++;
        if (rd_data[31:0] !== 32'd13 || rd_data[63:32] !== 32'd31) begin
            errors++; $display("FAIL fill got %h %h expected 13 31", rd_data[31:0], rd_data[63:32]);
        end
        @(negedge clk);
        run_clear(1'b1, busy_cnt, done_cnt, done_at);
        checks++;
        if (busy_cnt != 32) begin
            errors++; $display("FAIL clear_busy_cycles got %0d expected 32", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 32) begin
            errors++; $display("FAIL clear_done pulses %0d at %0d expected 1 at 32", done_cnt, done_at);
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk); set_rd(AW'(a), AW'(a)); #1;
            exp_q.push_back((a == 3) ? 32'h0000BEEF : 32'h0);
            exp = exp_q.pop_front(); checks++;
            if (rd_data[31:0] !== exp) begin
                errors++; $display("FAIL after_clear addr %0d got %h expected %h", a, rd_data[31:0], exp);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int busy_cnt, done_cnt, done_at;
        @(negedge clk);
        write_cycle(1'b1, 5'd25, 32'h55555555, 1'b1, 5'd31, 32'h66666666);
        clr_req = 1'b1; @(negedge clk); clr_req = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++; $display("FAIL midclear_busy got %b expected 1", clr_busy);
        end
        reset_b = 1'b0; set_rd(5'd25, 5'd31); #1;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags busy=%b done=%b expected 0 0", clr_busy, clr_done);
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (rd_data[31:0] !== exp) begin
            errors++; $display("FAIL rst_mid_r25 got %h expected %h", rd_data[31:0], exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (rd_data[63:32] !== exp) begin
            errors++; $display("FAIL rst_mid_r31 got %h expected %h", rd_data[63:32], exp);
        end
        @(negedge clk); reset_b = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        checks++;
        if (busy_cnt != 0 || done_cnt != 0) begin
            errors++; $display("FAIL rst_mid_quiet busy %0d done %0d expected 0 0", busy_cnt, done_cnt);
        end
        write_cycle(1'b1, 5'd30, 32'h30303030, 1'b0, '0, '0);
        run_clear(1'b0, busy_cnt, done_cnt, done_at);
        checks++;
        if (busy_cnt != 32 || done_cnt != 1) begin
            errors++; $display("FAIL reclear busy %0d done %0d expected 32 1", busy_cnt, done_cnt);
        end
        set_rd(5'd30, 5'd25); #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reclear_data got %h expected 0", rd_data);
        end
    endtask

    initial begin
        reset_b = 1'b0; rd_addr = '0; clr_req = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_zero_bypass();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
